uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits.
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; SHALL be a power of two, at least 2.
REQ-003 sysclk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising sysclk.
REQ-005 rx_data  input  WIDTH  received byte from the receiver; stable while rx_status is high.
REQ-006 rx_status  input  1  receiver byte-complete level from the baud domain; a rising edge marks a new byte.
REQ-007 rd_en  input  1  consumer pop request; ignored while empty.
REQ-008 dout  output  WIDTH  head-of-FIFO byte, first-word-fall-through.
REQ-009 empty  output  1  high when count==0.
REQ-010 full  output  1  high when count==DEPTH.
REQ-011 count  output  log2(DEPTH)+1  number of stored bytes.
REQ-012 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-013 clr_overrun  input  1  single-cycle clear of overrun.

Function
REQ-014 rx_status SHALL pass through a two-flop synchroniser; a rising edge on the synchronised signal SHALL form a one-cycle write strobe.
REQ-015 On the write strobe, rx_data SHALL be sampled and written; total latency is 3 sysclk cycles from rx_status rising to the byte being visible in count.
REQ-016 rx_status held high SHALL produce exactly one write; a new write needs rx_status low for at least 2 sysclk cycles first.
REQ-017 dout SHALL equal the oldest stored byte whenever empty is low; dout is don't-care while empty.
REQ-018 rd_en with empty low SHALL advance the read pointer on that clock edge; the next byte appears on dout the following cycle.
REQ-019 rd_en with empty high SHALL change no state.
REQ-020 Write strobe with full low SHALL store the byte and advance the write pointer.
REQ-021 Write strobe with full high and no accepted read SHALL drop the byte and set overrun; pointers and count stay unchanged.
REQ-022 Write strobe with full high and an accepted read in the same cycle SHALL store the byte; count stays DEPTH; overrun is not set.
REQ-023 A simultaneous accepted read and write at any non-empty level SHALL leave count unchanged.
REQ-024 A write to an empty FIFO with rd_en high SHALL store the byte; the read is ignored per REQ-019.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be maintained explicitly, not derived from the pointers.
REQ-026 If clr_overrun and a new overrun event occur in the same cycle, overrun SHALL be set (set wins).
REQ-027 empty, full and count SHALL be registered values, consistent with each other on every cycle.

Reset
REQ-028 On reset: both pointers 0, count 0, empty 1, full 0, overrun 0, synchroniser flops 0, and no write strobe in the cycle after reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes; storage array contents need not be cleared.
REQ-030 A rx_status already high when reset releases SHALL NOT generate a write until it has gone low and risen again.

Structure
REQ-031 WIDTH and DEPTH defaults, and the count-width function, SHALL live in the shared uart package used by the receiver, controller and sender.
REQ-032 The synchroniser plus rising-edge detector SHALL be one sub-module, edge_sync (ports sysclk, reset, din, pulse), reusable for the sender's tx_en.
REQ-033 Storage SHALL be a DEPTH x WIDTH register array, with no vendor RAM primitives.

Verification
REQ-034 Reset, then rx_status rising with rx_data=8'hA5 -> count=1 and dout=8'hA5 three cycles later; empty falls the same cycle.
REQ-035 Write bytes 8'h00 through 8'h0F, then 16 pops -> full=1 after the 16th write, dout follows 00..0F in order, empty=1 after the last pop.
REQ-036 Fill to 16, then a 17th byte 8'hFF with rd_en low -> byte dropped, overrun=1, count=16; clr_overrun pulse -> overrun=0.
REQ-037 Full FIFO, 17th write strobe coincident with rd_en -> count stays 16, overrun stays 0, 8'hFF read out last.
REQ-038 Write 8 bytes, pop 8 bytes, repeat 3 times (pointer wrap) -> data order preserved, count returns to 0 each round.
REQ-039 rx_status held high for 50 cycles -> exactly one write; reset asserted with count=5 -> count=0 and empty=1 the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART parameters and helpers used by the receiver, controller and sender.
package uart_pkg;

  localparam int UART_WIDTH = 8;
  localparam int UART_DEPTH = 16;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus rising-edge detector; pulse is one cycle wide, 2 cycles after din rises.
// A din already high when reset releases is ignored until it has been seen low.
module edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] valid_q;

  // valid_q marks when sync_q holds a real sample rather than its reset value.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 2'b00;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      valid_q <= {valid_q[0], 1'b1};
      if (valid_q[1] && !sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a synchronised byte-complete strobe; byte visible in count 3 cycles after rx_status rises.
// First-word-fall-through read; writes while full are dropped and flagged in sticky overrun unless a read frees a slot.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH,
  parameter int DEPTH = UART_DEPTH
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          rx_data,
  input  logic                      rx_status,
  input  logic                      rd_en,
  input  logic                      clr_overrun,
  output logic [WIDTH-1:0]          dout,
  output logic                      empty,
  output logic                      full,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overrun_q, overrun_d;
  logic             wr_stb;
  logic             rd_acc;
  logic             wr_acc;
  logic             drop;

  edge_sync u_edge_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .din    (rx_status),
    .pulse  (wr_stb)
  );

  // A read in the same cycle frees the slot a full-FIFO write needs.
  always_comb begin
    rd_acc    = rd_en & ~empty_q;
    wr_acc    = wr_stb & (~full_q | rd_acc);
    drop      = wr_stb & full_q & ~rd_acc;
    wr_ptr_d  = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
    overrun_d = drop | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge sysclk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign dout    = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo; queue-based reference model with a negedge scoreboard monitor.
module tb_uart_rx_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic         sysclk;
  logic         reset;
  logic [W-1:0] rx_data;
  logic         rx_status;
  logic         rd_en;
  logic         clr_overrun;
  logic [W-1:0] dout;
  logic         empty;
  logic         full;
  logic [4:0]   count;
  logic         overrun;

  uart_rx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_status   (rx_status),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           chk_en = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] sb_q[$];
  bit           movr = 0;
  int           due_e[$];
  logic [W-1:0] due_d[$];
  bit           prev_rx = 0;
  int           low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge: reads before writes, a full FIFO accepts a write only alongside a read.
  task automatic model_edge(input bit rd, input bit clr, input bit rst);
    bit           rd_acc;
    bit           wr;
    bit           was_full;
    bit           dropped;
    logic [W-1:0] wd;
    if (rst) begin
      mq.delete();
      sb_q.delete();
      due_e.delete();
      due_d.delete();
      movr   = 0;
      chk_en = 1;
      return;
    end
    rd_acc   = rd && (mq.size() > 0);
    was_full = (mq.size() == D);
    wr       = (due_e.size() > 0) && (due_e[0] == cyc);
    wd       = '0;
    dropped  = 0;
    if (wr) begin
      void'(due_e.pop_front());
      wd = due_d.pop_front();
    end
    if (rd_acc) void'(mq.pop_front());
    if (wr) begin
      if (!was_full || rd_acc) begin
        mq.push_back(wd);
        sb_q.push_back(wd);
      end else begin
        dropped = 1;
      end
    end
    if (dropped) movr = 1;
    else if (clr) movr = 0;
  endtask

  // A qualified rise (low >= 2 cycles since reset/last byte) lands in the FIFO on the third edge.
  task automatic cycle(input bit rx, input logic [W-1:0] d, input bit rd, input bit clr, input bit rst);
    reset       = rst;
    rx_status   = rx;
    rx_data     = d;
    rd_en       = rd;
    clr_overrun = clr;
    if (!rst && rx && !prev_rx && low_run >= 2) begin
      due_e.push_back(cyc + 3);
      due_d.push_back(d);
    end
    if (rst || rx) low_run = 0;
    else low_run++;
    prev_rx = rx;
    @(posedge sysclk);
    cyc++;
    model_edge(rd, clr, rst);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int hold, input logic [7:0] rd_m, input logic [7:0] clr_m);
    for (int i = 0; i < hold + 3; i++) begin
      cycle(i < hold, d, (i < 8) ? rd_m[i] : 1'b0, (i < 8) ? clr_m[i] : 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pops(input int n);
    repeat (n) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: status against the model every cycle, dout against the expected stream on each consumed byte.
  always @(negedge sysclk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == D));
      check("overrun", 32'(overrun), 32'(movr));
      if (empty === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dout at cycle %0d: got %0h with nothing expected", cyc, dout);
        end else begin
          check("dout", 32'(dout), 32'(sb_q[0]));
          if (rd_en && !reset) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rx_status = 1'b0; rx_data = '0; rd_en = 1'b0; clr_overrun = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(4);

    send(8'hA5, 2, 8'h00, 8'h00);
    idle(2);
    pops(1);
    idle(2);

    for (int b = 0; b < 16; b++) send(8'(b), 2, 8'h00, 8'h00);
    idle(2);
    pops(16);
    idle(2);

    for (int b = 0; b < 16; b++) send(8'h10 + 8'(b), 2, 8'h00, 8'h00);
    send(8'hFF, 2, 8'h00, 8'h00);
    idle(2);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(2);
    pops(16);
    idle(2);

    for (int b = 0; b < 16; b++) send(8'h20 + 8'(b), 2, 8'h00, 8'h00);
    send(8'hFF, 2, 8'b0000_0100, 8'h00);
    pops(16);
    idle(2);

    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 8; b++) send(8'($urandom), 2, 8'h00, 8'h00);
      pops(8);
      idle(2);
    end

    send(8'h5C, 50, 8'h00, 8'h00);
    pops(2);
    for (int b = 0; b < 5; b++) send(8'h40 + 8'(b), 1, 8'h00, 8'h00);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);

    repeat (2) cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    idle(3);
    send(8'h3C, 2, 8'h00, 8'h00);
    pops(2);
    idle(2);

    for (int k = 0; k < 40; k++) begin
      send(8'($urandom), $urandom_range(1, 4), 8'($urandom & $urandom & $urandom),
           ($urandom_range(0, 7) == 0) ? 8'h04 : 8'h00);
    end
    for (int k = 0; k < 40; k++) begin
      send(8'($urandom), $urandom_range(1, 4), 8'($urandom | $urandom),
           ($urandom_range(0, 7) == 0) ? 8'h02 : 8'h00);
    end
    pops(20);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
